load_store_unit: RTL and testbench

//  Core-side front end for Data_Memory: accepts LB/LH/LW/LBU/LHU/SB/SH/SW requests.
//  - Drives the word-wide memory port (WE, A, WD, RD).
//  - Sub-word stores use a read-modify-write sequence, because memory has one word write enable.
//  - Loads are sign- or zero-extended.
//  - Sits between the execute stage and Data_Memory.

---
 rtl/load_store_unit.sv | 80 ++++++++
 tb/tb_load_store_unit.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// load_store_unit: RV32I load/store front end for a word-wide Data_Memory, sub-word stores via read-modify-write.
// Optional MISALIGN_TRAP_EN: misaligned H/W accesses trap with resp_err instead of masking low address bits.
module load_store_unit #(
    parameter int ADDR_WIDTH = 32,
    parameter int XLEN = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [XLEN-1:0]       req_wdata,
    output logic                  resp_valid,
    output logic [XLEN-1:0]       resp_rdata,
    output logic                  resp_err,
    output logic                  mem_WE,
    output logic [ADDR_WIDTH-1:0] mem_A,
    output logic [XLEN-1:0]       mem_WD,
    input  logic [XLEN-1:0]       mem_RD
);
    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;
    state_t state, state_nx;
    logic                  we_q, err_q, mis;
    logic [2:0]            f3_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [XLEN-1:0]       wdata_q, word_q, merged, ld_data;
    logic [7:0]            b;
    logic [15:0]           h;
`ifdef MISALIGN_TRAP_EN
    assign mis = req_funct3[1] ? |req_addr[1:0] : (req_funct3[0] & req_addr[0]);
`else
    assign mis = 1'b0;
`endif
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            f3_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            word_q  <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && req_valid) begin
                we_q    <= req_we;
                err_q   <= mis;
                f3_q    <= req_funct3;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
            if (state == READ) word_q <= mem_RD;
        end
    end
    // Full-word stores skip the read; everything else reads first
    always_comb begin
        state_nx = state == IDLE  ? (!req_valid ? IDLE : mis ? RESP : (req_we && req_funct3[1]) ? WRITE : READ)
                 : state == READ  ? (we_q ? WRITE : RESP)
                 : state == WRITE ? RESP : IDLE;
    end
    assign b = word_q[{addr_q[1:0], 3'b000} +: 8];
    assign h = word_q[{addr_q[1], 4'b0000} +: 16];
    assign ld_data = f3_q[1] ? word_q
                   : f3_q[0] ? {{16{~f3_q[2] & h[15]}}, h}
                   : {{24{~f3_q[2] & b[7]}}, b};
    always_comb begin
        merged = word_q;
        if (f3_q[0]) merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
        else merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
    end
    assign req_ready  = state == IDLE;
    assign resp_valid = state == RESP;
    assign resp_err   = resp_valid & err_q;
    assign resp_rdata = (resp_valid && !we_q && !err_q) ? ld_data : '0;
    assign mem_WE     = state == WRITE;
    assign mem_A      = (state == READ || state == WRITE) ? {addr_q[ADDR_WIDTH-1:2], 2'b00} : '0;
    assign mem_WD     = mem_WE ? (f3_q[1] ? wdata_q : merged) : '0;
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: table-driven scoreboard bench for load_store_unit with a behavioural word memory.
// Honours MISALIGN_TRAP_EN the same way as the design.
module tb_load_store_unit;
    logic        clk = 1'b0, rst = 1'b0;
    logic        req_valid = 1'b0, req_we = 1'b0;
    logic [2:0]  req_funct3 = '0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic        req_ready, resp_valid, resp_err, mem_WE;
    logic [31:0] resp_rdata, mem_A, mem_WD, mem_RD;
    logic [31:0] mem [0:63];
    int          we_cnt = 0;
    int          total = 0, bad = 0;

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr, wdata, rdata;
        logic        err;
        int          lat, wes;
        logic [31:0] mw;
    } vec_t;
    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } exp_t;
    exp_t sbq[$];
    localparam int N = 19;
    vec_t vt [N];

    load_store_unit dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_WE(mem_WE), .mem_A(mem_A), .mem_WD(mem_WD), .mem_RD(mem_RD)
    );

    always #5 clk = ~clk;
    assign mem_RD = mem[mem_A[7:2]];
    always @(posedge clk) begin
        if (mem_WE) begin
            mem[mem_A[7:2]] <= mem_WD;
            we_cnt <= we_cnt + 1;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic run(input vec_t v, input int idx);
        int n = 0;
        int w0;
        exp_t e;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("v%0d ready", idx), {31'b0, req_ready}, 32'd1);
        req_valid = 1'b1; req_we = v.we; req_funct3 = v.f3; req_addr = v.addr; req_wdata = v.wdata;
        sbq.push_back('{v.rdata, v.err, v.lat});
        w0 = we_cnt;
        @(negedge clk);
        req_valid = 1'b0; req_we = 1'($urandom); req_funct3 = 3'($urandom);
        req_addr = $urandom; req_wdata = $urandom;
        n = 1;
        while (!resp_valid && n < 8) begin
            @(negedge clk);
            n++;
        end
        e = sbq.pop_front();
        chk($sformatf("v%0d resp_valid", idx), {31'b0, resp_valid}, 32'd1);
        if (resp_valid) begin
            chk($sformatf("v%0d rdata", idx), resp_rdata, e.rdata);
            chk($sformatf("v%0d err", idx), {31'b0, resp_err}, {31'b0, e.err});
            chk($sformatf("v%0d latency", idx), n, e.lat);
        end
        chk($sformatf("v%0d writes", idx), we_cnt - w0, v.wes);
        if (v.we) chk($sformatf("v%0d memword", idx), mem[v.addr[7:2]], v.mw);
        @(negedge clk);
        chk($sformatf("v%0d idle", idx), {30'b0, resp_valid, req_ready}, 32'd1);
    endtask

    initial begin
        int w0, seen;
        vt[0]  = '{1'b1, 3'b010, 32'h4, 32'hABCDEFFF, 32'h0, 1'b0, 2, 1, 32'hABCDEFFF};
        vt[1]  = '{1'b0, 3'b010, 32'h4, 32'h0, 32'hABCDEFFF, 1'b0, 2, 0, 32'h0};
        vt[2]  = '{1'b0, 3'b000, 32'h5, 32'h0, 32'hFFFFFFEF, 1'b0, 2, 0, 32'h0};
        vt[3]  = '{1'b0, 3'b100, 32'h5, 32'h0, 32'h000000EF, 1'b0, 2, 0, 32'h0};
        vt[4]  = '{1'b0, 3'b001, 32'h6, 32'h0, 32'hFFFFABCD, 1'b0, 2, 0, 32'h0};
        vt[5]  = '{1'b0, 3'b101, 32'h6, 32'h0, 32'h0000ABCD, 1'b0, 2, 0, 32'h0};
        vt[6]  = '{1'b0, 3'b000, 32'h4, 32'h0, 32'hFFFFFFFF, 1'b0, 2, 0, 32'h0};
        vt[7]  = '{1'b0, 3'b100, 32'h7, 32'h0, 32'h000000AB, 1'b0, 2, 0, 32'h0};
        vt[8]  = '{1'b0, 3'b001, 32'h4, 32'h0, 32'hFFFFEFFF, 1'b0, 2, 0, 32'h0};
        vt[9]  = '{1'b1, 3'b010, 32'h8, 32'h11223344, 32'h0, 1'b0, 2, 1, 32'h11223344};
        vt[10] = '{1'b1, 3'b000, 32'hA, 32'h000000AA, 32'h0, 1'b0, 3, 1, 32'h11AA3344};
        vt[11] = '{1'b1, 3'b001, 32'h8, 32'h0000BEEF, 32'h0, 1'b0, 3, 1, 32'h11AABEEF};
        vt[12] = '{1'b0, 3'b010, 32'h8, 32'h0, 32'h11AABEEF, 1'b0, 2, 0, 32'h0};
        vt[13] = '{1'b0, 3'b011, 32'h8, 32'h0, 32'h11AABEEF, 1'b0, 2, 0, 32'h0};
        vt[14] = '{1'b1, 3'b100, 32'hB, 32'h12345655, 32'h0, 1'b0, 3, 1, 32'h55AABEEF};
`ifdef MISALIGN_TRAP_EN
        vt[15] = '{1'b0, 3'b010, 32'h6, 32'h0, 32'h0, 1'b1, 1, 0, 32'h0};
        vt[16] = '{1'b0, 3'b001, 32'h5, 32'h0, 32'h0, 1'b1, 1, 0, 32'h0};
        vt[17] = '{1'b1, 3'b010, 32'h9, 32'h12345678, 32'h0, 1'b1, 1, 0, 32'h55AABEEF};
        vt[18] = '{1'b0, 3'b010, 32'h8, 32'h0, 32'h55AABEEF, 1'b0, 2, 0, 32'h0};
`else
        vt[15] = '{1'b0, 3'b010, 32'h6, 32'h0, 32'hABCDEFFF, 1'b0, 2, 0, 32'h0};
        vt[16] = '{1'b0, 3'b001, 32'h5, 32'h0, 32'hFFFFEFFF, 1'b0, 2, 0, 32'h0};
        vt[17] = '{1'b1, 3'b010, 32'h9, 32'h12345678, 32'h0, 1'b0, 2, 1, 32'h12345678};
        vt[18] = '{1'b0, 3'b010, 32'h8, 32'h0, 32'h12345678, 1'b0, 2, 0, 32'h0};
`endif
        repeat (3) @(negedge clk);
        chk("reset ready", {31'b0, req_ready}, 32'd1);
        chk("reset resp", {29'b0, resp_valid, resp_err, mem_WE}, 32'd0);
        chk("reset rdata", resp_rdata, 32'd0);
        chk("reset mem_A", mem_A, 32'd0);
        chk("reset mem_WD", mem_WD, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        for (int i = 0; i < N; i++) run(vt[i], i);

        // Reset arriving while an RMW store sits in READ must cancel it
        run('{1'b1, 3'b010, 32'hC, 32'hCAFEF00D, 32'h0, 1'b0, 2, 1, 32'hCAFEF00D}, 100);
        w0 = we_cnt;
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000; req_addr = 32'hC; req_wdata = 32'h77;
        @(negedge clk);
        req_valid = 1'b0;
        chk("rmw read addr", mem_A, 32'hC);
        chk("rmw read busy", {30'b0, req_ready, mem_WE}, 32'd0);
        rst = 1'b0;
        #1;
        chk("abort outputs", {29'b0, mem_WE, resp_valid, resp_err}, 32'd0);
        chk("abort ready", {31'b0, req_ready}, 32'd1);
        chk("abort mem_A", mem_A, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (resp_valid || mem_WE || !req_ready) seen++;
        end
        chk("abort quiet", seen, 0);
        chk("abort writes", we_cnt - w0, 0);
        chk("abort memword", mem[3], 32'hCAFEF00D);

        // Back-to-back: second request taken only on the cycle after resp_valid
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h4; req_wdata = 32'h0;
        @(negedge clk);
        chk("b2b read", {30'b0, req_ready, resp_valid}, 32'd0);
        @(negedge clk);
        chk("b2b resp", {30'b0, req_ready, resp_valid}, 32'd1);
        chk("b2b rdata1", resp_rdata, 32'hABCDEFFF);
        @(negedge clk);
        chk("b2b idle", {30'b0, req_ready, resp_valid}, 32'd2);
        @(negedge clk);
        req_valid = 1'b0;
        chk("b2b second accept", {30'b0, req_ready, resp_valid}, 32'd0);
        @(negedge clk);
        chk("b2b resp2", {30'b0, req_ready, resp_valid}, 32'd1);
        chk("b2b rdata2", resp_rdata, 32'hABCDEFFF);
        @(negedge clk);
        chk("b2b done", {30'b0, req_ready, resp_valid}, 32'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
endmodule
